// File: rtl/sub_b_pipe.sv
// Registered sub_b arithmetic block with a DEPTH-entry result FIFO behind valid/ready handshakes.
// Optional build macro SUB_B_PIPE_SAT_EN saturates the sum to WIDTH bits.
module sub_b_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           testi1_b,
  input  logic [WIDTH-1:0]           testi2_b,
  input  logic [WIDTH-1:0]           testi3_b,
  input  logic                       acc_clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             testo1_b,
  output logic [WIDTH-1:0]           testo2_b,
  output logic [WIDTH-1:0]           testo1_sub_b,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = 3 * WIDTH + 1;

  typedef struct packed {
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bxc;
    logic [WIDTH-1:0] acc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             push, pop;
  logic [WIDTH:0]   sum_full, sum_w;
  logic [WIDTH-1:0] acc_next;
  entry_t           new_entry, head;

  // Ready depends only on the count register so it never combinationally follows out_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign sum_full = {1'b0, testi1_b} + {1'b0, testi2_b};
`ifdef SUB_B_PIPE_SAT_EN
  assign sum_w = sum_full[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : sum_full;
`else
  assign sum_w = sum_full;
`endif

  // A clear coinciding with a push restarts the accumulator from this transaction's a^c.
  assign acc_next  = acc_clr ? (push ? (testi1_b ^ testi3_b) : '0)
                             : (acc_q ^ testi1_b ^ testi3_b);
  assign new_entry = '{sum: sum_w, bxc: testi2_b ^ testi3_b, acc: acc_next};

  assign head         = mem_q[rd_ptr_q];
  assign testo1_b     = head.sum;
  assign testo2_b     = head.bxc;
  assign testo1_sub_b = head.acc;
  assign fill_level   = count_q;

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    if (push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push || acc_clr) begin
      acc_d = acc_next;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      // NOTE: storage is reset too, because head outputs must read 0 straight after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mem_q    <= mem_d;
    end
  end

  initial_width_check : assert property (@(posedge clk) ENTRY_W == $bits(entry_t));

endmodule
